ff_network_sequencer: RTL and testbench
=======================================

# ff_network_sequencer

Bus-master controller that sequences a `ff_network` instance through its memory-mapped register interface. It streams a weight set in and commits it, then loops forever: accept one input sample, commit it, wait for the network to finish, and read the outputs back as a result stream. It sits between the system-side stream sources/sinks and the `ff_network` `in_d/address/read/write/out_d/ready` port group. It replaces hand-driven bus sequences with a single handshaked block.

## Interface
- `LENGHT_I`, 2, input neurons; `LENGHT_MID`, 2, hidden neurons; `LENGHT_O`, 2, output neurons
- `WIDTH`, 4, bus data width (`in_d`/`out_d`)
- `WIDTH_ADDR`, `$clog2(N_W+LENGHT_I+LENGHT_O+3)`, bus address width; `N_W = LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O`
- `TIMEOUT`, 64, max cycles spent waiting for `net_ready`
- `clk` in 1: single clock; all logic on rising edge
- `reset` in 1: synchronous, active-high
- `cfg_data` in WIDTH, `cfg_valid` in 1, `cfg_ready` out 1: weight word stream
- `smp_data` in WIDTH, `smp_valid` in 1, `smp_ready` out 1: input-neuron word stream
- `res_data` out WIDTH, `res_valid` out 1, `res_ready` in 1, `res_last` out 1: output-neuron result stream
- `reload` in 1: request a new weight load
- `net_in_d` out WIDTH, `net_address` out WIDTH_ADDR, `net_write` out 1, `net_read` out 1: network bus, all registered
- `net_out_d` in WIDTH, `net_ready` in 1: network read data and computation-done
- `weights_loaded` out 1, `busy` out 1, `timeout_err` out 1 (sticky): status

## Operation
- Address map: weights 0..N_W-1; weight commit N_W; inputs N_W+1..N_W+LENGHT_I; input commit N_W+LENGHT_I+1; outputs N_W+LENGHT_I+2..N_W+LENGHT_I+1+LENGHT_O. Commit data is all-ones (`{WIDTH{1'b1}}`).
- FSM states: LOAD_W, COMMIT_W, LOAD_I, COMMIT_I, WAIT_NET, READ_O, RES_HOLD.
- LOAD_W: `cfg_ready`=1. The k-th accepted word is written to address k. After N_W words the FSM moves to COMMIT_W.
- COMMIT_W: one write of all-ones to address N_W. Then `weights_loaded`←1 and the FSM moves to LOAD_I.
- LOAD_I: `smp_ready`=1. The j-th accepted word is written to N_W+1+j. After LENGHT_I words the FSM moves to COMMIT_I.
  - `reload` is honoured only in LOAD_I with j==0. It clears `weights_loaded`, resets k and goes to LOAD_W.
  - Mid-sample `reload` is ignored.
- COMMIT_I: one write of all-ones to N_W+LENGHT_I+1, then WAIT_NET.
- WAIT_NET: a cycle counter runs.
  - `net_ready`=1 → READ_O.
  - Counter reaches TIMEOUT-1 without `net_ready` → `timeout_err`←1 and the FSM returns to LOAD_I. The sample is dropped and no results are emitted.
- READ_O: issue a one-cycle `net_read` to output address m, capture `net_out_d`, present it on `res_data` with `res_valid`=1, then go to RES_HOLD.
- RES_HOLD: hold `res_data`/`res_valid` until `res_ready`.
  - `res_last`=1 for m==LENGHT_O-1.
  - After the handshake: m<LENGHT_O-1 → READ_O with m+1; otherwise LOAD_I.
- `busy`=1 in every state except LOAD_I with j==0.
- `cfg_ready`/`smp_ready` are 0 in all other states. Words offered there are not consumed.
- `timeout_err` clears only on `reset`.

## Timing
- Reset (synchronous, sampled at a rising edge): state→LOAD_W, k=j=m=0, wait counter 0.
  - Outputs forced to 0: `net_write`, `net_read`, `net_in_d`, `net_address`, `res_*`, `weights_loaded`, `busy`, `timeout_err`, `cfg_ready`, `smp_ready`.
  - `cfg_ready` rises the first cycle after `reset` deasserts.
- Reset mid-operation aborts any write, read or hold immediately. The FSM returns to LOAD_W and weights must be reloaded.
- Write latency: a stream word accepted at edge t appears as `net_write`=1 with `net_address`/`net_in_d` during cycle t+1. `net_write` is a single-cycle pulse per word.
- Back-to-back `cfg_valid`/`smp_valid` produces one write per cycle. Gaps produce `net_write`=0 cycles, and address/data hold their last value.
- The commit write occurs in the cycle after the last data write.
- Read: `net_read`=1 for exactly one cycle with the address. `net_out_d` is sampled at the next edge (one-cycle read latency). `res_valid` rises the cycle after that sample.
- `res_data` is stable while `res_valid`=1 and `res_ready`=0.
- `net_ready` asserted in the same cycle WAIT_NET is entered is accepted.

## Test plan
Defaults: N_W=8, inputs at 9/10, commit at 11, outputs at 12/13, WIDTH_ADDR=4.

- Weight load: after reset, stream cfg 1..8 back-to-back.
  - Expect writes addr 0..7 with data 1..8, then a write of 4'b1111 to addr 8.
  - `weights_loaded`=1 next cycle; `smp_ready`=1.
- Sample with gaps: smp words 3, 5 with an idle cycle between.
  - Expect write 3@9, one idle cycle, write 5@10, write 4'b1111@11, `busy`=1.
- Result path: model asserts `net_ready` 5 cycles after commit and returns 6@12 and 9@13.
  - Expect `res_data`=6 (`res_last`=0), then 9 (`res_last`=1).
  - Hold `res_ready`=0 for 3 cycles on the first result: data stays stable and no second read is issued.
- Timeout: `net_ready` never rises after commit.
  - `timeout_err`=1 after 64 cycles, no `res_valid`, `smp_ready`=1 again.
- Reload: `reload`=1 in idle LOAD_I.
  - `weights_loaded`→0 and `cfg_ready`=1; the next cfg word is written to addr 0.
  - `reload` asserted after the first sample word has no effect.
- Reset mid-sample: assert `reset` after the write to addr 9.
  - All outputs are 0 next cycle, and `cfg_ready` is 1 the cycle after deassert.

Source files
------------

// File: rtl/ff_network_sequencer.sv
// Bus master for an ff_network: streams a weight set in, then loops feeding one
// input sample, waiting for the network and streaming the output neurons back.
module ff_network_sequencer #(
    parameter int LENGHT_I   = 2,
    parameter int LENGHT_MID = 2,
    parameter int LENGHT_O   = 2,
    parameter int WIDTH      = 4,
    parameter int WIDTH_ADDR = $clog2(LENGHT_I*LENGHT_MID + LENGHT_MID*LENGHT_O + LENGHT_I + LENGHT_O + 3),
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      smp_data,
    input  logic                  smp_valid,
    output logic                  smp_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_last,
    input  logic                  reload,
    output logic [WIDTH-1:0]      net_in_d,
    output logic [WIDTH_ADDR-1:0] net_address,
    output logic                  net_write,
    output logic                  net_read,
    input  logic [WIDTH-1:0]      net_out_d,
    input  logic                  net_ready,
    output logic                  weights_loaded,
    output logic                  busy,
    output logic                  timeout_err
);
    localparam int N_W = LENGHT_I*LENGHT_MID + LENGHT_MID*LENGHT_O;
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef logic [WIDTH_ADDR-1:0] addr_t;
    localparam addr_t K_LAST    = addr_t'(N_W - 1);
    localparam addr_t J_LAST    = addr_t'(LENGHT_I - 1);
    localparam addr_t M_LAST    = addr_t'(LENGHT_O - 1);
    localparam addr_t A_WCOMMIT = addr_t'(N_W);
    localparam addr_t A_IBASE   = addr_t'(N_W + 1);
    localparam addr_t A_ICOMMIT = addr_t'(N_W + LENGHT_I + 1);
    localparam addr_t A_OBASE   = addr_t'(N_W + LENGHT_I + 2);
    localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ONES   = '1;

    typedef enum logic [2:0] {
        LOAD_W, COMMIT_W, LOAD_I, COMMIT_I, WAIT_NET, READ_O, RES_HOLD
    } state_t;

    state_t        state, nxt;
    addr_t         k, j, m;
    logic [TW-1:0] wcnt;
    logic          cfg_fire, smp_fire, reload_ok, tmo_hit, nxt_idle;

    assign cfg_fire = cfg_valid & cfg_ready;
    assign smp_fire = smp_valid & smp_ready;
    // A word accepted in the same cycle as reload wins, so nothing is silently dropped.
    assign reload_ok = (state == LOAD_I) && (j == '0) && reload && !smp_fire;
    assign tmo_hit   = (state == WAIT_NET) && !net_ready && (wcnt == T_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD_W;
        else       state <= nxt;
    end

    always_comb begin
        nxt      = state;
        nxt_idle = 1'b0;
        case (state)
            LOAD_W:   if (cfg_fire && k == K_LAST) nxt = COMMIT_W;
            COMMIT_W: nxt = LOAD_I;
            LOAD_I: begin
                if (reload_ok)                      nxt = LOAD_W;
                else if (smp_fire && j == J_LAST)   nxt = COMMIT_I;
            end
            COMMIT_I: nxt = WAIT_NET;
            WAIT_NET: begin
                if (net_ready)    nxt = READ_O;
                else if (tmo_hit) nxt = LOAD_I;
            end
            READ_O:   nxt = RES_HOLD;
            RES_HOLD: if (res_ready) nxt = (m == M_LAST) ? LOAD_I : READ_O;
            default:  nxt = LOAD_W;
        endcase
        // Idle means sitting in LOAD_I with no sample word taken yet.
        if (nxt == LOAD_I)
            nxt_idle = !(state == LOAD_I && (j != '0 || smp_fire));
    end

    // All outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            k <= '0; j <= '0; m <= '0; wcnt <= '0;
            net_write <= 1'b0; net_read <= 1'b0; net_in_d <= '0; net_address <= '0;
            res_data <= '0; res_valid <= 1'b0; res_last <= 1'b0;
            weights_loaded <= 1'b0; busy <= 1'b0; timeout_err <= 1'b0;
            cfg_ready <= 1'b0; smp_ready <= 1'b0;
        end else begin
            net_write <= 1'b0;
            net_read  <= 1'b0;
            cfg_ready <= (nxt == LOAD_W);
            smp_ready <= (nxt == LOAD_I);
            busy      <= !nxt_idle;
            case (state)
                LOAD_W: if (cfg_fire) begin
                    net_write <= 1'b1; net_address <= k; net_in_d <= cfg_data;
                    k <= k + 1'b1;
                end
                COMMIT_W: begin
                    net_write <= 1'b1; net_address <= A_WCOMMIT; net_in_d <= ONES;
                    weights_loaded <= 1'b1; k <= '0; j <= '0;
                end
                LOAD_I: begin
                    if (reload_ok) begin
                        weights_loaded <= 1'b0; k <= '0;
                    end else if (smp_fire) begin
                        net_write <= 1'b1; net_address <= A_IBASE + j; net_in_d <= smp_data;
                        j <= (j == J_LAST) ? '0 : j + 1'b1;
                    end
                end
                COMMIT_I: begin
                    net_write <= 1'b1; net_address <= A_ICOMMIT; net_in_d <= ONES;
                    wcnt <= '0;
                end
                WAIT_NET: begin
                    if (net_ready) begin
                        m <= '0; net_read <= 1'b1; net_address <= A_OBASE;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1; j <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                READ_O: begin
                    res_data <= net_out_d; res_valid <= 1'b1; res_last <= (m == M_LAST);
                end
                RES_HOLD: if (res_ready) begin
                    res_valid <= 1'b0; res_last <= 1'b0;
                    if (m != M_LAST) begin
                        m <= m + 1'b1; net_read <= 1'b1; net_address <= A_OBASE + m + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ff_network_sequencer.sv
// Bench for ff_network_sequencer: transaction-level network model, a vector table,
// directed corner sequences and randomized samples checked against expected bus traffic.
module tb_ff_network_sequencer;
    localparam int LI = 2, LM = 2, LO = 2, W = 4, AW = 4, TMO = 64;
    localparam int NW = LI*LM + LM*LO;
    localparam logic [3:0] A_IC = 4'(NW + LI + 1);
    localparam logic [3:0] A_O0 = 4'(NW + LI + 2);
    localparam logic [3:0] A_O1 = 4'(NW + LI + 3);

    logic clk = 1'b0, reset = 1'b1;
    logic [W-1:0] cfg_data = '0, smp_data = '0, res_data, net_in_d, net_out_d;
    logic cfg_valid = 1'b0, smp_valid = 1'b0, res_ready = 1'b0, reload = 1'b0;
    logic cfg_ready, smp_ready, res_valid, res_last, net_write, net_read;
    logic weights_loaded, busy, timeout_err;
    logic net_ready;
    logic [AW-1:0] net_address;

    ff_network_sequencer #(.LENGHT_I(LI), .LENGHT_MID(LM), .LENGHT_O(LO), .WIDTH(W),
                           .WIDTH_ADDR(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last),
        .reload(reload),
        .net_in_d(net_in_d), .net_address(net_address), .net_write(net_write), .net_read(net_read),
        .net_out_d(net_out_d), .net_ready(net_ready),
        .weights_loaded(weights_loaded), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; int c; } bus_t;
    bus_t wr_log[$];
    bus_t rd_log[$];
    always @(negedge clk) begin
        if (net_write === 1'b1) wr_log.push_back('{int'(net_address), int'(net_in_d), cyc});
        if (net_read === 1'b1)  rd_log.push_back('{int'(net_address), 0, cyc});
    end

    // Network model: outputs held in a small memory, ready after a programmable delay.
    logic [3:0] out_mem [2];
    int rdy_delay = -1, rdy_cnt = -1;
    assign net_out_d = (net_read && net_address == A_O0) ? out_mem[0] :
                       (net_read && net_address == A_O1) ? out_mem[1] : 4'h0;
    initial net_ready = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            net_ready = 1'b0; rdy_cnt = -1;
        end else if (net_write === 1'b1 && net_address == A_IC && net_in_d == 4'hF) begin
            net_ready = 1'b0; rdy_cnt = rdy_delay;
        end else if (rdy_cnt > 0) begin
            rdy_cnt--;
        end else if (rdy_cnt == 0) begin
            net_ready = 1'b1; rdy_cnt = -1;
        end
        if (net_read === 1'b1) net_ready = 1'b0;
    end

    int tests = 0, fails = 0;
    bit exp_tmo = 1'b0;
    logic [3:0] wts [NW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_cfg(input logic [3:0] d, input int gap);
        int n = 0;
        cfg_data = d; cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("cfg_accept_bound", 0, 1);
        @(negedge clk); cfg_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_smp(input logic [3:0] d, input int gap);
        int n = 0;
        smp_data = d; smp_valid = 1'b1;
        while (smp_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("smp_accept_bound", 0, 1);
        @(negedge clk); smp_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic load_weights(input int maxgap);
        wr_log.delete();
        for (int i = 0; i < NW; i++) send_cfg(wts[i], int'($urandom_range(0, maxgap)));
        repeat (3) @(negedge clk);
        check("wload_count", wr_log.size(), NW + 1);
        for (int i = 0; i < wr_log.size() && i <= NW; i++) begin
            check($sformatf("wload_addr%0d", i), wr_log[i].addr, i);
            if (i < NW) check($sformatf("wload_data%0d", i), wr_log[i].data, wts[i]);
            else        check("wcommit_data", wr_log[i].data, 15);
        end
        if (wr_log.size() == NW + 1) check("wcommit_next_cycle", wr_log[NW].c - wr_log[NW-1].c, 1);
        check("weights_loaded", weights_loaded, 1);
        check("smp_ready_idle", smp_ready, 1);
        check("busy_idle", busy, 0);
    endtask

    // Expected sample traffic: two input writes d01 cycles apart, then the commit.
    task automatic chk_wr(input logic [3:0] x0, input logic [3:0] x1, input int d01);
        check("swr_count", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            check("swr0_addr", wr_log[0].addr, NW + 1); check("swr0_data", wr_log[0].data, x0);
            check("swr1_addr", wr_log[1].addr, NW + 2); check("swr1_data", wr_log[1].data, x1);
            check("scommit_addr", wr_log[2].addr, A_IC); check("scommit_data", wr_log[2].data, 15);
            check("swr_spacing", wr_log[1].c - wr_log[0].c, d01);
            check("scommit_next_cycle", wr_log[2].c - wr_log[1].c, 1);
        end
    endtask

    task automatic run_sample(input logic [3:0] x0, input logic [3:0] x1, input logic [3:0] o0,
                              input logic [3:0] o1, input int dly, input int gap, input bit mrl,
                              input bit rr_rand, input bit tmo);
        logic [3:0] got [$];
        logic       gotl [$];
        int  n = 0, tmo_c = -1;
        bit  was_tmo = exp_tmo;
        out_mem[0] = o0; out_mem[1] = o1; rdy_delay = dly;
        wr_log.delete(); rd_log.delete();
        send_smp(x0, gap);
        if (mrl) begin reload = 1'b1; @(negedge clk); reload = 1'b0; end
        send_smp(x1, 0);
        while (!(smp_ready === 1'b1 && busy === 1'b0) && n < 300) begin
            res_ready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (res_valid === 1'b1 && res_ready) begin got.push_back(res_data); gotl.push_back(res_last); end
            if (timeout_err === 1'b1 && tmo_c < 0) tmo_c = cyc;
            @(negedge clk); n++;
        end
        if (timeout_err === 1'b1 && tmo_c < 0) tmo_c = cyc;
        res_ready = 1'b0;
        check("sample_done_bound", n < 300, 1);
        chk_wr(x0, x1, gap + 1 + (mrl ? 1 : 0));
        if (tmo) begin
            exp_tmo = 1'b1;
            check("tmo_res_count", got.size(), 0);
            check("tmo_read_count", rd_log.size(), 0);
            if (!was_tmo && wr_log.size() == 3) check("tmo_latency", tmo_c - wr_log[2].c, TMO);
        end else begin
            check("res_count", got.size(), 2);
            check("read_count", rd_log.size(), 2);
            if (got.size() == 2) begin
                check("res0_data", got[0], o0); check("res0_last", gotl[0], 0);
                check("res1_data", got[1], o1); check("res1_last", gotl[1], 1);
            end
            if (rd_log.size() == 2) begin
                check("read0_addr", rd_log[0].addr, A_O0); check("read1_addr", rd_log[1].addr, A_O1);
            end
        end
        check("timeout_err_sticky", timeout_err, exp_tmo);
        check("weights_kept", weights_loaded, 1);
    endtask

    typedef struct { logic [3:0] x0, x1, o0, o1; int dly; int gap; bit mrl; bit tmo; } vec_t;
    vec_t tbl [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rv_c;
        tbl[0] = '{4'h1, 4'h2, 4'h3, 4'h4,  0, 0, 1'b0, 1'b0};
        tbl[1] = '{4'hF, 4'h0, 4'hA, 4'h5,  3, 2, 1'b0, 1'b0};
        tbl[2] = '{4'h7, 4'h8, 4'h0, 4'h0, -1, 0, 1'b0, 1'b1};
        tbl[3] = '{4'h2, 4'h9, 4'hC, 4'h3,  1, 0, 1'b1, 1'b0};
        tbl[4] = '{4'hE, 4'h1, 4'hF, 4'hF, 12, 1, 1'b0, 1'b0};
        out_mem[0] = '0; out_mem[1] = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs", {net_write, net_read, net_in_d, net_address, res_valid, res_last, res_data,
                                weights_loaded, busy, timeout_err, cfg_ready, smp_ready}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("cfg_ready_after_reset", cfg_ready, 1);
        check("busy_load_w", busy, 1);

        for (int i = 0; i < NW; i++) wts[i] = 4'(i + 1);
        load_weights(0);

        // Sample with an idle cycle between words, then backpressure on the first result.
        out_mem[0] = 4'd6; out_mem[1] = 4'd9; rdy_delay = 5;
        wr_log.delete(); rd_log.delete(); res_ready = 1'b0;
        send_smp(4'd3, 0);
        check("busy_mid_sample", busy, 1);
        @(negedge clk);
        send_smp(4'd5, 0);
        n = 0;
        while (res_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("res0_wait_bound", n < 100, 1);
        rv_c = cyc;
        check("hold_read_count0", rd_log.size(), 1);
        if (rd_log.size() > 0) begin
            check("hold_read_addr", rd_log[0].addr, A_O0);
            check("read_to_valid", rv_c - rd_log[0].c, 1);
        end
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, 6);
            check("hold_last", res_last, 0);
            @(negedge clk);
        end
        check("hold_no_second_read", rd_log.size(), 1);
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("res1_wait_bound", n < 100, 1);
        check("res1_data", res_data, 9);
        check("res1_last", res_last, 1);
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
        n = 0;
        while (!(smp_ready === 1'b1 && busy === 1'b0) && n < 100) begin @(negedge clk); n++; end
        check("idle_after_results", n < 100, 1);
        chk_wr(4'd3, 4'd5, 2);

        for (int i = 0; i < 5; i++)
            run_sample(tbl[i].x0, tbl[i].x1, tbl[i].o0, tbl[i].o1, tbl[i].dly, tbl[i].gap,
                       tbl[i].mrl, 1'b0, tbl[i].tmo);

        // Reload from idle: weights drop and the next word lands at address 0.
        reload = 1'b1; @(negedge clk); reload = 1'b0;
        check("reload_wl_clear", weights_loaded, 0);
        check("reload_cfg_ready", cfg_ready, 1);
        check("reload_smp_ready", smp_ready, 0);
        for (int i = 0; i < NW; i++) wts[i] = 4'($urandom_range(0, 15));
        load_weights(1);

        // Reset right after the first sample write.
        wr_log.delete();
        send_smp(4'hB, 0);
        check("pre_reset_write", {net_write, net_address, net_in_d}, {1'b1, 4'(NW + 1), 4'hB});
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs", {net_write, net_read, net_in_d, net_address, res_valid, res_last, res_data,
                                   weights_loaded, busy, timeout_err, cfg_ready, smp_ready}, 0);
        reset = 1'b0; exp_tmo = 1'b0;
        @(negedge clk);
        check("cfg_ready_after_midreset", cfg_ready, 1);
        for (int i = 0; i < NW; i++) wts[i] = 4'($urandom_range(0, 15));
        load_weights(2);

        for (int it = 0; it < 25; it++) begin
            int  dly;
            bit  tmo;
            if ($urandom_range(0, 5) == 0) begin
                reload = 1'b1; @(negedge clk); reload = 1'b0;
                for (int i = 0; i < NW; i++) wts[i] = 4'($urandom_range(0, 15));
                load_weights(2);
            end
            tmo = ($urandom_range(0, 9) == 0);
            dly = tmo ? -1 : int'($urandom_range(0, 20));
            run_sample(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       dly, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), 1'b1, tmo);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
